// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 data mux, with a per-grant hold limit.
// Optional owner lock input is enabled by defining ARB_LOCK_EN.
module rr_mux4_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] d,
`ifdef ARB_LOCK_EN
  input  logic                lock,
`endif
  output logic [3:0]          gnt,
  output logic [1:0]          sel,
  output logic                valid,
  output logic [DATA_W-1:0]   y,
  output logic                fsm_state
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t     state, state_n;
  logic [3:0] gnt_n;
  logic [1:0] sel_n, ptr, ptr_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] pick_idle, pick_next;
  logic       owner_req, hold_lock;

  // Returns {found, index} of the first set bit of mask searching base, base+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] k;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = base + 2'(i);
      if (mask[k]) r = {1'b1, k};
    end
    return r;
  endfunction

`ifdef ARB_LOCK_EN
  assign hold_lock = lock;
`else
  assign hold_lock = 1'b0;
`endif

  assign pick_idle = rr_pick(req, ptr);
  assign pick_next = rr_pick(req & ~gnt, sel + 2'd1);
  assign owner_req = req[sel];

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (pick_idle[2]) begin
          state_n = GRANT;
          sel_n   = pick_idle[1:0];
          gnt_n   = 4'b0001 << pick_idle[1:0];
          ptr_n   = pick_idle[1:0] + 2'd1;
          cnt_n   = 4'd1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (pick_next[2]) begin
            sel_n = pick_next[1:0];
            gnt_n = 4'b0001 << pick_next[1:0];
            ptr_n = pick_next[1:0] + 2'd1;
            cnt_n = 4'd1;
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            ptr_n   = sel + 2'd1;
          end
        end else if (cnt >= HOLD_MAX && pick_next[2] && !hold_lock) begin
          sel_n = pick_next[1:0];
          gnt_n = 4'b0001 << pick_next[1:0];
          ptr_n = pick_next[1:0] + 2'd1;
          cnt_n = 4'd1;
        end else if (cnt < HOLD_MAX) begin
          // A lone owner (or a locked one) stays, with cnt pinned at the limit.
          cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  assign valid     = (state == GRANT);
  assign fsm_state = state;

  always_comb begin
    y = '0;
    if (valid) y = d[sel*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter (DATA_W=1, MAX_HOLD=4); covers lock behaviour when ARB_LOCK_EN is set.
module tb_rr_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;
  logic       lock;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic [0:0] y;
  logic       fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  rr_mux4_arbiter #(.DATA_W(1), .MAX_HOLD(4)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .d(d),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt),
    .sel(sel),
    .valid(valid),
    .y(y),
    .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_y"}, 32'(y), 32'h0);
  endtask

  task automatic check_owner(input string tag, input logic [1:0] k);
    logic [3:0] dv;
    dv = d;
    check({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << k));
    check({tag, "_sel"}, 32'(sel), 32'(k));
    check({tag, "_valid"}, 32'(valid), 32'h1);
    check({tag, "_y"}, 32'(y), 32'(dv[k]));
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; d = 4'b0000; lock = 1'b0;
    tick(); tick();
    check_idle("reset");
    check("reset_sel", 32'(sel), 32'h0);
    rst = 1'b0;

    // Single requester; y follows the live d lane.
    req = 4'b0100; d = 4'b1010;
    tick();
    check_owner("single", 2'd2);
    check("single_y0", 32'(y), 32'h0);
    d = 4'b1110;
    #1;
    check("single_y1", 32'(y), 32'h1);
    req = 4'b0000;
    tick();
    check_idle("single_rel");
    check("single_sel_held", 32'(sel), 32'h2);

    // Reset in the middle of a grant.
    req = 4'b0001;
    tick();
    check_owner("pre_rst", 2'd0);
    rst = 1'b1;
    tick();
    check_idle("mid_rst");
    rst = 1'b0; req = 4'b0000;
    tick();

    // All four requesting: each owner holds exactly 4 cycles.
    d = 4'b0101;
    for (int i = 0; i < 20; i++) exp_q.push_back(2'(i / 4));
    req = 4'b1111;
    while (exp_q.size() > 0) begin
      tick();
      check_owner("rr", exp_q.pop_front());
    end
    req = 4'b0000;
    tick();
    check_idle("rr_rel");

    // Owner 1 drops after 2 cycles while 3 waits: no idle bubble.
    req = 4'b1010;
    tick();
    check_owner("early_a", 2'd1);
    tick();
    check_owner("early_b", 2'd1);
    req = 4'b1000;
    tick();
    check_owner("early_hand", 2'd3);
    req = 4'b0000;
    tick();
    check_idle("early_rel");

    // Lone owner keeps the grant past the limit, then yields at once.
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_owner("lone", 2'd0);
    end
    req = 4'b0101;
    tick();
    check_owner("lone_yield", 2'd2);
    req = 4'b0000;
    tick();
    check_idle("lone_rel");

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_idle("rst2");

`ifdef ARB_LOCK_EN
    req = 4'b0011; lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_owner("lock", 2'd0);
    end
    lock = 1'b0;
    tick();
    check_owner("unlock", 2'd1);
`else
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_owner("limit", 2'd0);
    end
    tick();
    check_owner("limit_rot", 2'd1);
`endif
    req = 4'b0000;
    tick();
    check_idle("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
